imm_encode: RTL
===============

# imm_encode

Streaming immediate encoder, the inverse of the decode-side immediate extender. It takes an architectural immediate value and a base instruction word, then scatters the immediate bits into RISC-V I/S/B/J field positions. It also checks the value against each format's range and alignment rules. Results are buffered in a 2-entry output FIFO with valid/ready handshakes on both sides. The block feeds instruction-memory preload and self-test generators.

## Interface
- CNT_W, 16, width of the saturating accept/error counters
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_immsrc  in  2  format: 00 I, 01 S, 10 B, 11 J (same code points as decode side)
- in_imm  in  32  immediate as a signed 32-bit value (byte offset for B/J)
- in_base  in  32  instruction word supplying all non-immediate bits
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate out of range or misaligned for the format
- cnt_ok  out  CNT_W  accepted requests with no error, saturating
- cnt_err  out  CNT_W  accepted requests with an error, saturating

## Operation
- Encoding: clear the format's immediate bit positions in in_base, then OR in the immediate bits.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
- Range check: I/S require sign-extending imm[11:0] to reproduce in_imm. B requires the same with imm[12:0] and imm[0]==0. J requires the same with imm[20:0] and imm[0]==0.
- On error: the truncated encoding is still emitted, out_err=1, and cnt_err increments. The entry is never dropped.
- FIFO: 2 entries of {instr, err}, in order. Encode is combinational at push; entries are stored already encoded.
- in_ready = reset_n && (count < 2). It has no combinational dependence on out_ready.
- Counters: +1 on each accepted request. They hold at all-ones and never wrap.

## Timing
- Latency: a request accepted in cycle N with the FIFO empty gives out_valid=1 in cycle N+1.
- Throughput: 1 per cycle sustained while out_ready=1 (count stays at 1).
- Simultaneous push and pop: the count is unchanged and the head advances. This cannot occur at count==2, because in_ready=0 there.
- Full (count==2): in_ready=0 and the upstream holds its request. Empty: out_valid=0, and out_instr/out_err hold their last value.
- Counters update in the cycle after acceptance, together with the FIFO write.
- Reset (asserted anywhere, including mid-transfer): immediately out_valid=0, out_instr=0, out_err=0, count=0, pointers=0, cnt_ok=0, cnt_err=0, in_ready=0. All in-flight entries are discarded.
- After reset_n deasserts: in_ready=1 in the same cycle.

## Structure
- Package imm_pkg holds:
  - immsrc_t enum (IMM_I, IMM_S, IMM_B, IMM_J).
  - Per-format immediate-field masks.
  - Per-format signed range widths (12, 12, 13, 21).
- Sub-module imm_insert is purely combinational: in (immsrc, imm, base), out (instr, err). It is reused by test generators.
- The FIFO, handshake logic and counters live in imm_encode.

## Test plan
- I-type: base 0x00000013, imm 0xFFFFFFFF -> out_instr 0xFFF00013, err 0, cnt_ok 1. Also imm 0x00000800 -> err 1, cnt_err 1.
- S-type: base 0x00002023, imm 8 -> 0x00002423, err 0.
- B-type: base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3, err 0. Also imm 3 -> err 1 (misaligned).
- J-type: base 0x0000006F, imm 8 -> 0x0080006F. Also imm 0x00100000 -> err 1.
- Backpressure with out_ready=0 and 3 back-to-back requests:
  - The first two are accepted and in_ready drops; the third is held.
  - Then raise out_ready -> three results in order, one per cycle, no loss or duplication.
- Counter saturation and reset:
  - With CNT_W=2, 5 accepts -> cnt_ok stays at 3.
  - Assert reset_n=0 with 2 entries queued -> out_valid 0 and counters 0 immediately.
  - After release, in_ready=1 and the next result is fresh.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and constants for the RISC-V immediate encoder.
// Format codes match the decode-side immediate extender.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } entry_t;

    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    localparam int unsigned RANGE_W_I = 12;
    localparam int unsigned RANGE_W_S = 12;
    localparam int unsigned RANGE_W_B = 13;
    localparam int unsigned RANGE_W_J = 21;

    // True when v survives truncation to w bits and sign extension back to 32.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
        logic [31:0] upper;
        upper = 32'hFFFF_FFFF << (w - 1);
        return ((v & upper) == 32'd0) || ((v & upper) == upper);
    endfunction

endpackage

// File: rtl/imm_insert.sv
// Scatters an immediate into the I/S/B/J field positions of a base instruction word.
// Latency: purely combinational.
// Backpressure: none; the caller owns all flow control.
module imm_insert
    import imm_pkg::*;
(
    input  immsrc_t     i_immsrc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_base,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic [31:0] w_mask;
    logic [31:0] w_bits;
    int unsigned w_width;
    logic        w_align;

    always_comb begin
        w_mask  = MASK_I;
        w_bits  = {i_imm[11:0], 20'd0};
        w_width = RANGE_W_I;
        w_align = 1'b0;
        case (i_immsrc)
            IMM_I: ;
            IMM_S: begin
                w_mask  = MASK_S;
                w_bits  = {i_imm[11:5], 13'd0, i_imm[4:0], 7'd0};
                w_width = RANGE_W_S;
            end
            IMM_B: begin
                w_mask  = MASK_B;
                w_bits  = {i_imm[12], i_imm[10:5], 13'd0, i_imm[4:1], i_imm[11], 7'd0};
                w_width = RANGE_W_B;
                w_align = 1'b1;
            end
            IMM_J: begin
                w_mask  = MASK_J;
                w_bits  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'd0};
                w_width = RANGE_W_J;
                w_align = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_instr = (i_base & ~w_mask) | w_bits;
    assign o_err   = !fits_signed(i_imm, w_width) || (w_align && i_imm[0]);

endmodule

// File: rtl/imm_encode.sv
// Streaming immediate encoder: encodes at push, buffers {instr, err} in a 2-entry FIFO.
// Latency: 1 cycle from acceptance to out_valid when empty; 1/cycle sustained.
// Backpressure: in_ready drops when both entries are occupied, independent of out_ready.
module imm_encode
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_immsrc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    entry_t [1:0]     r_mem;
    entry_t           r_hold;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_cnt_ok;
    logic [CNT_W-1:0] r_cnt_err;

    entry_t w_entry;
    entry_t w_head;
    logic   w_push;
    logic   w_pop;

    imm_insert u_insert (
        .i_immsrc (immsrc_t'(in_immsrc)),
        .i_imm    (in_imm),
        .i_base   (in_base),
        .o_instr  (w_entry.instr),
        .o_err    (w_entry.err)
    );

    assign in_ready  = reset_n && !r_count[1];
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // When empty, present the most recently consumed entry so outputs hold.
    assign w_head    = out_valid ? r_mem[r_rd_ptr] : r_hold;
    assign out_instr = w_head.instr;
    assign out_err   = w_head.err;
    assign cnt_ok    = r_cnt_ok;
    assign cnt_err   = r_cnt_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem     <= '0;
            r_hold    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
                if (w_entry.err) begin
                    if (r_cnt_err != '1) r_cnt_err <= r_cnt_err + 1'b1;
                end else begin
                    if (r_cnt_ok != '1) r_cnt_ok <= r_cnt_ok + 1'b1;
                end
            end
            if (w_pop) begin
                r_hold   <= r_mem[r_rd_ptr];
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
